// File: rtl/tff_toggle_rx.sv
`default_nettype none
// ============================================================================
// Module   : tff_toggle_rx
// Purpose  : Recovers one event per level change of a TFF toggle line, buffers
//            events for a valid/ready consumer and returns an ack toggle.
// Revision : 1.0 - initial release
// ============================================================================
module tff_toggle_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int PEND_W      = 4,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tog_in,
  output logic              event_valid,
  input  logic              event_ready,
  output logic [PEND_W-1:0] pending,
  output logic              ack_tog,
  output logic              ovf,
  output logic [CNT_W-1:0]  event_cnt
);

  localparam logic [PEND_W-1:0] c_pend_max = {PEND_W{1'b1}};

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [PEND_W-1:0]      r_pending;
  logic                   r_ack_tog;
  logic                   r_ovf;
  logic [CNT_W-1:0]       r_event_cnt;

  logic w_s_out;
  logic w_push;
  logic w_pop;

  assign w_s_out = r_sync[SYNC_STAGES-1];
  assign w_push  = w_s_out ^ r_prev;
  assign w_pop   = event_valid & event_ready;

  // Synchroniser chain plus edge history; tog_in may be asynchronous to clk.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], tog_in};
      r_prev <= w_s_out;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending   <= '0;
      r_ack_tog   <= 1'b0;
      r_ovf       <= 1'b0;
      r_event_cnt <= '0;
    end else begin
      if (w_push) begin
        r_event_cnt <= r_event_cnt + 1'b1;
      end
      if (w_pop) begin
        r_ack_tog <= ~r_ack_tog;
      end
      // Simultaneous push and pop cancel, so a full buffer never flags ovf then.
      if (w_push && !w_pop) begin
        if (r_pending == c_pend_max) begin
          r_ovf <= 1'b1;
        end else begin
          r_pending <= r_pending + 1'b1;
        end
      end else if (w_pop && !w_push) begin
        r_pending <= r_pending - 1'b1;
      end
    end
  end

  assign event_valid = (r_pending != '0);
  assign pending     = r_pending;
  assign ack_tog     = r_ack_tog;
  assign ovf         = r_ovf;
  assign event_cnt   = r_event_cnt;

endmodule
`default_nettype wire
